// File: rtl/boron_pkg.sv
// Shared BORON definitions: block geometry, word slice type, skid FSM
// encoding, and the word-level XOR layer with its inverse.
package boron_pkg;

  localparam int BORON_WORD_LEN  = 16;
  localparam int BORON_BLOCK_LEN = 64;
  localparam int BORON_ROUNDS    = 25;

  typedef logic [BORON_WORD_LEN-1:0]  boron_word_t;
  typedef logic [BORON_BLOCK_LEN-1:0] boron_block_t;

  typedef enum logic [1:0] {
    SKID_EMPTY = 2'd0,
    SKID_ONE   = 2'd1,
    SKID_FULL  = 2'd2
  } skid_state_e;

  // y0 = w0^w1, y1 = w1^w2, y2 = w2^w3, y3 = w3
  function automatic boron_block_t boron_xor_layer(input boron_block_t x);
    boron_word_t w0, w1, w2, w3;
    w0 = x[15:0];
    w1 = x[31:16];
    w2 = x[47:32];
    w3 = x[63:48];
    return {w3, w2 ^ w3, w1 ^ w2, w0 ^ w1};
  endfunction

  // Inverse layer, unwound from the top word downwards.
  function automatic boron_block_t boron_xor_layer_inv(input boron_block_t y);
    boron_word_t w0, w1, w2, w3;
    w3 = y[63:48];
    w2 = y[47:32] ^ w3;
    w1 = y[31:16] ^ w2;
    w0 = y[15:0]  ^ w1;
    return {w3, w2, w1, w0};
  endfunction

endpackage

// File: rtl/boron_skid_buffer.sv
// Generic 2-entry valid/ready register slice. in_ready is decoded from the
// state register only, so out_ready never reaches in_ready combinationally.
//
//   state      | meaning
//   SKID_EMPTY | no entry held
//   SKID_ONE   | main register valid
//   SKID_FULL  | main and skid registers valid, upstream stalled
module boron_skid_buffer
  import boron_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_payload,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_payload
);

  skid_state_e  state, state_nxt;
  logic [W-1:0] m_data, s_data;
  logic         accept, drain;

  assign accept = in_valid && in_ready;
  assign drain  = out_valid && out_ready;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= SKID_EMPTY;
    else     state <= state_nxt;
  end

  // Next-state decode; flush overrides any same-cycle handshake.
  always_comb begin
    state_nxt = state;
    if (flush) begin
      state_nxt = SKID_EMPTY;
    end else begin
      unique case (state)
        SKID_EMPTY: if (accept) state_nxt = SKID_ONE;
        SKID_ONE: begin
          if (accept && !drain)      state_nxt = SKID_FULL;
          else if (!accept && drain) state_nxt = SKID_EMPTY;
        end
        SKID_FULL:  if (drain) state_nxt = SKID_ONE;
        default:    state_nxt = SKID_EMPTY;
      endcase
    end
  end

  // Handshake outputs decoded from the state register.
  always_comb begin
    out_valid = (state != SKID_EMPTY);
    in_ready  = (state != SKID_FULL);
  end

  // Payload registers; only written on accept or on FULL->ONE promotion, so
  // an undriven in_payload while in_valid is low never gets captured.
  always_ff @(posedge clk) begin
    if (rst) begin
      m_data <= '0;
      s_data <= '0;
    end else if (!flush) begin
      unique case (state)
        SKID_EMPTY: if (accept) m_data <= in_payload;
        SKID_ONE: begin
          if (accept && drain)       m_data <= in_payload;
          else if (accept && !drain) s_data <= in_payload;
        end
        SKID_FULL: begin
          if (drain) begin
            m_data <= s_data;
            s_data <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  assign out_payload = m_data;

endmodule

// File: rtl/boron_xor_layer_stage.sv
// BORON XOR-layer round stage: applies the word XOR layer at capture, carries
// the round tag through a skid buffer, and counts completed output blocks.
module boron_xor_layer_stage
  import boron_pkg::*;
#(
  parameter int DATA_LEN   = BORON_WORD_LEN,
  parameter int ROUND_W    = 5,
  parameter int LAST_ROUND = BORON_ROUNDS
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [4*DATA_LEN-1:0] in_data,
  input  logic [ROUND_W-1:0]    in_round,
  input  logic                  flush,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [4*DATA_LEN-1:0] out_data,
  output logic [ROUND_W-1:0]    out_round,
  output logic                  out_last,
  output logic [15:0]           blk_count
);

  localparam int BLK = 4 * DATA_LEN;
  localparam int PW  = BLK + ROUND_W;
  localparam logic [ROUND_W-1:0] LAST_TAG = ROUND_W'(LAST_ROUND);

  logic [BLK-1:0] xor_result;
  logic [PW-1:0]  out_payload;

  // Native BORON width reuses the shared layer; other widths slice generically.
  if (BLK == BORON_BLOCK_LEN) begin : g_native
    always_comb xor_result = boron_xor_layer(in_data);
  end else begin : g_generic
    // Word-wise XOR with the next-higher word; top word passes through.
    always_comb begin
      xor_result = in_data;
      for (int i = 0; i < 3; i++) begin
        xor_result[i*DATA_LEN +: DATA_LEN] =
          in_data[i*DATA_LEN +: DATA_LEN] ^ in_data[(i+1)*DATA_LEN +: DATA_LEN];
      end
    end
  end

  boron_skid_buffer #(.W(PW)) u_skid (
    .clk         (clk),
    .rst         (rst),
    .flush       (flush),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_payload  ({xor_result, in_round}),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_payload (out_payload)
  );

  assign out_data  = out_payload[PW-1:ROUND_W];
  assign out_round = out_payload[ROUND_W-1:0];
  assign out_last  = (out_round == LAST_TAG);

  // Completed-transfer counter; a flush cycle swallows the drain.
  always_ff @(posedge clk) begin
    if (rst)                               blk_count <= '0;
    else if (!flush && out_valid && out_ready) blk_count <= blk_count + 16'd1;
  end

endmodule

// File: doc/boron_xor_layer_stage.md
Name: boron_xor_layer_stage

Overview:
- Registered BORON round stage directly downstream of the round permutation (four 16-bit word rotations by 1/4/7/9).
- Consumes the permuted 64-bit state, applies the word-level XOR layer, and forwards the result with its round index.
- Uses a valid/ready handshake and a 2-entry skid buffer, so back-pressure from the next round (key addition / S-box) never drops or duplicates a block.
- Sustains full throughput of one block per clock.

Parameters:
- DATA_LEN, 16, width of one state word; the block width is 4*DATA_LEN.
- ROUND_W, 5, width of the round index tag (covers BORON's 25 rounds).
- LAST_ROUND, 25, round index value that asserts out_last.

Ports:
- clk  in  1  single clock; everything is rising-edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  upstream holds a valid permuted state.
- in_ready  out  1  stage can accept; transfer happens when in_valid && in_ready.
- in_data  in  4*DATA_LEN  permutation output; w0=[15:0], w1=[31:16], w2=[47:32], w3=[63:48].
- in_round  in  ROUND_W  round index of in_data.
- flush  in  1  synchronous discard of all held entries.
- out_valid  out  1  out_data is valid.
- out_ready  in  1  downstream accepts; transfer happens when out_valid && out_ready.
- out_data  out  4*DATA_LEN  XOR-layer result.
- out_round  out  ROUND_W  tag travelling with out_data.
- out_last  out  1  asserted when out_round == LAST_ROUND.
- blk_count  out  16  count of completed output transfers; wraps at 16'hFFFF->0.

Behaviour:
- XOR layer (combinational, applied at capture):
  - y0 = w0^w1, y1 = w1^w2, y2 = w2^w3, y3 = w3.
  - out_data = {y3,y2,y1,y0}.
  - The layer is bijective; inverse: w3=y3, w2=y2^w3, w1=y1^w2, w0=y0^w1.
- Storage: main register M plus skid register S, each holding {data, round, valid}.
- States: EMPTY (no entry held), ONE (M valid), FULL (M and S valid).
  - out_valid = M.valid.
  - in_ready = !S.valid, taken from a register; there is no combinational path from out_ready to in_ready.
- Transitions (accept = in_valid && in_ready; drain = out_valid && out_ready):
  - EMPTY, accept -> ONE; M gets the result.
  - ONE, accept && drain -> ONE; M is replaced by the new result.
  - ONE, accept && !drain -> FULL; S gets the result.
  - ONE, !accept && drain -> EMPTY.
  - FULL, drain -> ONE; M gets S, S is cleared. No accept is possible in FULL.
- Latency: input transfer in cycle N gives out_valid in cycle N+1.
- Ordering: strict FIFO order; round tags never reorder.
- out_data, out_round and out_last stay stable while out_valid && !out_ready.
- blk_count increments by 1 on each drain and wraps modulo 2^16.
- flush:
  - Next state is EMPTY; same-cycle accept and drain are ignored.
  - blk_count does not increment that cycle and otherwise keeps its value.
  - in_ready is 1 the following cycle.
- Reset (rst high at a clock edge, including mid-transfer or while FULL):
  - out_valid=0, in_ready=1, out_data=0, out_round=0, out_last=0, blk_count=0.
  - All held entries are discarded.
  - rst has priority over flush and over any handshake.
- in_data is don't-care when in_valid=0; X on in_data must not reach any register while in_valid=0.

Decomposition:
- Shared package boron_pkg:
  - BORON_WORD_LEN=16, BORON_BLOCK_LEN=64, BORON_ROUNDS=25.
  - A word-slice typedef for 16-bit words.
  - A function boron_xor_layer(64b)->64b, reused by the decrypt-side inverse and the reference model.
- One sub-module: boron_skid_buffer.
  - Generic 2-entry valid/ready register slice, parameterised by payload width.
  - This stage instantiates it with payload {xor_result, round}; the counter and out_last decode live in the top.

Test Plan:
- Single block: in_data=64'h0001_0002_0004_0008, round=3, out_ready=1 -> next cycle out_data=64'h0001_0003_0006_000C, out_round=3, out_last=0, blk_count=1.
- Streaming: 8 back-to-back blocks with out_ready=1 -> in_ready stays 1, 8 outputs on consecutive cycles, in order, blk_count=8.
- Back-pressure: 3 blocks offered, out_ready=0 -> in_ready drops after the 2nd accept; out_data holds block 0; release out_ready -> blocks 0,1,2 delivered in order, none lost or duplicated.
- Last round and all-ones: round=25 with in_data=64'hFFFF_FFFF_FFFF_FFFF -> out_data=64'hFFFF_0000_0000_0000, out_last=1.
- Flush and reset in FULL: flush -> next cycle out_valid=0, in_ready=1, blk_count unchanged; then rst while FULL -> all outputs zero, in_ready=1.
- Counter wrap: preload via 65535 drains, one more drain -> blk_count=0. Random out_ready toggling is checked against the inverse-XOR scoreboard.
